ifetch: RTL and testbench

- Instruction-fetch stage that consumes the program counter produced by the PC register.
- Issues a request/acknowledge read to instruction memory and holds the fetched instruction plus its PC until the decode stage takes it.
- Supplies the sequential next-PC candidate (PC+1) back to the next-PC mux.
- Flags a memory timeout.

---
 rtl/ifetch_pkg.sv | 13 +
 rtl/ifetch_timer.sv | 37 +++
 rtl/ifetch.sv | 128 ++++++++++++
 tb/tb_ifetch.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared constants for the fetch stage: PC width and the fetch FSM state encoding.
package ifetch_pkg;

    localparam int PC_W = 9;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t REQ  = 2'd1;
    localparam state_t FULL = 2'd2;
    localparam state_t ERR  = 2'd3;

endpackage

// File: rtl/ifetch_timer.sv
// Clearable wait counter for the fetch stage; expired_o flags the last permitted wait cycle.
module ifetch_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The FSM leaves REQ on this count, so the counter never reaches a wrap.
    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: reads imem at the supplied PC and holds the instruction for decode.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int N       = PC_W,
    parameter int W       = 32,
    parameter int TIMEOUT = 15
) (
    input  logic         btn,
    input  logic         rst,
    input  logic [N-1:0] i_pc,
    input  logic         pc_valid,
    output logic [N-1:0] o_pc_inc,
    output logic         o_busy,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [W-1:0] imem_data,
    output logic         o_valid,
    output logic [W-1:0] o_inst,
    output logic [N-1:0] o_inst_pc,
    input  logic         i_take,
    output logic         o_err,
    output logic [1:0]   o_state
);

    state_t         state_q, state_d;
    logic           load;
    logic           expired;
    logic [N-1:0]   addr_q, addr_d;
    logic [W-1:0]   inst_q, inst_d;
    logic [N-1:0]   inst_pc_q, inst_pc_d;

    assign o_pc_inc = i_pc + N'(1);

    always_ff @(posedge btn) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshakes: a PC transfers when pc_valid=1 and o_busy=0; the instruction
    // transfers when o_valid=1 and i_take=1; imem data is accepted when imem_req=1 and imem_ack=1.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pc_valid) begin
                    load    = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    state_d = FULL;
                end else if (expired) begin
                    state_d = ERR;
                end
            end
            FULL: begin
                if (i_take) begin
                    if (pc_valid) begin
                        load    = 1'b1;
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req = (state_q == REQ);
        o_valid  = (state_q == FULL);
        o_err    = (state_q == ERR);
        o_busy   = 1'b0;
        case (state_q)
            REQ:     o_busy = 1'b1;
            FULL:    o_busy = ~i_take;
            ERR:     o_busy = 1'b1;
            default: o_busy = 1'b0;
        endcase
    end

    ifetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (btn),
        .rst_i     (rst),
        .clear_i   (load),
        .enable_i  ((state_q == REQ) && !imem_ack),
        .expired_o (expired)
    );

    always_comb begin
        addr_d    = load ? i_pc : addr_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        if (state_q == REQ && imem_ack) begin
            inst_d    = imem_data;
            inst_pc_d = addr_q;
        end
    end

    always_ff @(posedge btn) begin
        if (rst) begin
            addr_q    <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            addr_q    <= addr_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    assign imem_addr = addr_q;
    assign o_inst    = inst_q;
    assign o_inst_pc = inst_pc_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed fetch scenarios, a transaction-level model checked every cycle.
module tb_ifetch;

    localparam int N       = 9;
    localparam int W       = 32;
    localparam int TIMEOUT = 15;

    logic         btn = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] i_pc = '0;
    logic         pc_valid = 1'b0;
    logic [N-1:0] o_pc_inc;
    logic         o_busy;
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ack = 1'b0;
    logic [W-1:0] imem_data = '0;
    logic         o_valid;
    logic [W-1:0] o_inst;
    logic [N-1:0] o_inst_pc;
    logic         i_take = 1'b0;
    logic         o_err;
    logic [1:0]   o_state;

    int n_tests = 0;
    int n_fail  = 0;

    ifetch #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .btn       (btn),
        .rst       (rst),
        .i_pc      (i_pc),
        .pc_valid  (pc_valid),
        .o_pc_inc  (o_pc_inc),
        .o_busy    (o_busy),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .o_valid   (o_valid),
        .o_inst    (o_inst),
        .o_inst_pc (o_inst_pc),
        .i_take    (i_take),
        .o_err     (o_err),
        .o_state   (o_state)
    );

    // ---------------- clock ----------------
    always #5 btn = ~btn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // pending = a read is outstanding; have = an instruction is waiting for decode.
    bit           m_pending = 0;
    bit           m_have    = 0;
    bit           m_err     = 0;
    int           m_wait    = 0;
    logic [N-1:0] m_addr    = '0;
    logic [W-1:0] m_inst    = '0;
    logic [N-1:0] m_inst_pc = '0;

    always @(posedge btn) begin
        logic [N-1:0] exp_inc;
        int           exp_state;
        if (rst) begin
            m_pending = 0; m_have = 0; m_err = 0; m_wait = 0;
            m_addr = '0; m_inst = '0; m_inst_pc = '0;
        end else if (m_err) begin
            m_err = 1;
        end else if (m_pending) begin
            if (imem_ack) begin
                m_pending = 0;
                m_have    = 1;
                m_inst    = imem_data;
                m_inst_pc = m_addr;
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    m_pending = 0;
                    m_err     = 1;
                end
            end
        end else if (!m_have || i_take) begin
            m_have = 0;
            if (pc_valid) begin
                m_pending = 1;
                m_addr    = i_pc;
                m_wait    = 0;
            end
        end
        #7;
        exp_inc   = (i_pc == 9'h1FF) ? 9'h000 : i_pc + 9'd1;
        exp_state = m_err ? 3 : m_pending ? 1 : m_have ? 2 : 0;
        chk("m_pc_inc",  o_pc_inc,  exp_inc);
        chk("m_req",     imem_req,  m_pending);
        chk("m_addr",    imem_addr, m_addr);
        chk("m_valid",   o_valid,   m_have);
        chk("m_inst",    o_inst,    m_inst);
        chk("m_inst_pc", o_inst_pc, m_inst_pc);
        chk("m_err",     o_err,     m_err);
        chk("m_busy",    o_busy,    m_pending || m_err || (m_have && !i_take));
        chk("m_state",   o_state,   exp_state);
    end

    // ---------------- driver ----------------
    // Each cyc() returns 2 time units after a rising edge; checks follow #5 later.
    task automatic cyc();
        @(posedge btn);
        #2;
    endtask

    task automatic issue(input logic [N-1:0] pc);
        i_pc     = pc;
        pc_valid = 1'b1;
        cyc();
        pc_valid = 1'b0;
    endtask

    initial begin
        repeat (3) cyc();
        rst = 1'b0;
        #5;
        chk("rst_valid", o_valid,  1'b0);
        chk("rst_req",   imem_req, 1'b0);
        chk("rst_err",   o_err,    1'b0);
        chk("rst_busy",  o_busy,   1'b0);
        chk("rst_state", o_state,  2'd0);
        chk("rst_inst",  o_inst,   32'h0);
        cyc();

        // Zero-wait fetch from the wrap address
        i_pc = 9'h1FF; pc_valid = 1'b1;
        #5 chk("t1_pc_inc", o_pc_inc, 9'h000);
        cyc();
        pc_valid = 1'b0; imem_ack = 1'b1; imem_data = 32'hDEADBEEF;
        #5;
        chk("t1_req",  imem_req,  1'b1);
        chk("t1_addr", imem_addr, 9'h1FF);
        cyc();
        imem_ack = 1'b0;
        #5;
        chk("t1_valid",   o_valid,   1'b1);
        chk("t1_inst",    o_inst,    32'hDEADBEEF);
        chk("t1_inst_pc", o_inst_pc, 9'h1FF);
        cyc();
        i_take = 1'b1;
        #5 chk("t1_busy_take", o_busy, 1'b0);
        cyc();
        i_take = 1'b0;
        #5 chk("t1_idle_valid", o_valid, 1'b0);
        cyc();

        // Ack delayed by three cycles
        issue(9'h004);
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin
                imem_ack = 1'b1; imem_data = 32'h12345678;
            end
            #5;
            chk("t2_req",  imem_req,  1'b1);
            chk("t2_addr", imem_addr, 9'h004);
            cyc();
        end
        imem_ack = 1'b0;
        #5;
        chk("t2_valid",   o_valid,   1'b1);
        chk("t2_inst_pc", o_inst_pc, 9'h004);
        chk("t2_inst",    o_inst,    32'h12345678);
        cyc();

        // Decode stalls in FULL; a PC offered meanwhile is ignored
        for (int k = 1; k <= 5; k++) begin
            if (k == 3) begin
                i_pc = 9'h010; pc_valid = 1'b1;
            end else begin
                pc_valid = 1'b0;
            end
            #5;
            chk("t3_hold_valid", o_valid,   1'b1);
            chk("t3_hold_busy",  o_busy,    1'b1);
            chk("t3_hold_pc",    o_inst_pc, 9'h004);
            chk("t3_hold_req",   imem_req,  1'b0);
            cyc();
        end
        i_take = 1'b1; pc_valid = 1'b1; i_pc = 9'h011;
        #5 chk("t3_busy_take", o_busy, 1'b0);
        cyc();
        i_take = 1'b0; pc_valid = 1'b0; imem_ack = 1'b1; imem_data = 32'h0000_0011;
        #5;
        chk("t3_b2b_req",   imem_req,  1'b1);
        chk("t3_b2b_addr",  imem_addr, 9'h011);
        chk("t3_b2b_valid", o_valid,   1'b0);
        cyc();
        imem_ack = 1'b0; i_take = 1'b1;
        #5 chk("t3_b2b_inst_pc", o_inst_pc, 9'h011);
        cyc();
        i_take = 1'b0;
        cyc();

        // No ack: timeout after exactly 15 request cycles
        issue(9'h020);
        for (int k = 1; k <= TIMEOUT; k++) begin
            #5 chk("t4_req_wait", imem_req, 1'b1);
            cyc();
        end
        #5;
        chk("t4_err",   o_err,    1'b1);
        chk("t4_req",   imem_req, 1'b0);
        chk("t4_valid", o_valid,  1'b0);
        chk("t4_busy",  o_busy,   1'b1);
        for (int k = 1; k <= 20; k++) begin
            pc_valid = (k == 5); i_pc = 9'h0AA; imem_ack = (k == 7);
            cyc();
            #5 chk("t4_err_sticky", o_err, 1'b1);
        end
        pc_valid = 1'b0; imem_ack = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #5 chk("t4_err_cleared", o_err, 1'b0);
        cyc();

        // Ack on the last permitted cycle beats the timeout
        issue(9'h030);
        for (int k = 1; k <= TIMEOUT; k++) begin
            if (k == TIMEOUT) begin
                imem_ack = 1'b1; imem_data = 32'hCAFE0015;
            end
            #5;
            cyc();
        end
        imem_ack = 1'b0;
        #5;
        chk("t5_valid",   o_valid,   1'b1);
        chk("t5_err",     o_err,     1'b0);
        chk("t5_inst",    o_inst,    32'hCAFE0015);
        chk("t5_inst_pc", o_inst_pc, 9'h030);
        i_take = 1'b1;
        cyc();
        i_take = 1'b0;
        cyc();

        // Reset in the second request cycle, ack arrives late
        issue(9'h040);
        #5;
        cyc();
        rst = 1'b1;
        #5 chk("t6_req_before_rst", imem_req, 1'b1);
        cyc();
        rst = 1'b0; imem_ack = 1'b1; imem_data = 32'h0BAD0BAD;
        #5;
        chk("t6_req",     imem_req,  1'b0);
        chk("t6_valid",   o_valid,   1'b0);
        chk("t6_err",     o_err,     1'b0);
        chk("t6_busy",    o_busy,    1'b0);
        chk("t6_addr",    imem_addr, 9'h000);
        chk("t6_inst",    o_inst,    32'h0);
        chk("t6_inst_pc", o_inst_pc, 9'h000);
        chk("t6_state",   o_state,   2'd0);
        cyc();
        imem_ack = 1'b0;
        #5;
        chk("t6_late_valid", o_valid, 1'b0);
        chk("t6_late_state", o_state, 2'd0);
        cyc();

        // Reset while holding an instruction discards it
        issue(9'h050);
        imem_ack = 1'b1; imem_data = 32'h5050_5050;
        cyc();
        imem_ack = 1'b0;
        #5 chk("t7_full", o_valid, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #5;
        chk("t7_valid", o_valid, 1'b0);
        chk("t7_inst",  o_inst,  32'h0);
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
